// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic unit: opcodes, FSM states and the
// width helper used to size the population-count accumulator.
package logic_unit_pkg;

    localparam logic [2:0] OP_NOT      = 3'b000;
    localparam logic [2:0] OP_AND      = 3'b001;
    localparam logic [2:0] OP_OR       = 3'b010;
    localparam logic [2:0] OP_XOR      = 3'b011;
    localparam logic [2:0] OP_NAND     = 3'b100;
    localparam logic [2:0] OP_NOR      = 3'b101;
    localparam logic [2:0] OP_XNOR     = 3'b110;
    localparam logic [2:0] OP_POPCOUNT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

    // Bits needed to hold any count from 0 to w inclusive.
    function automatic int count_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/logic_unit_popcount_chunk.sv
// Combinational ones counter for one CHUNK-bit slice of the popcount
// shift register.
module popcount_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0]              bits,
    output logic [$clog2(CHUNK+1)-1:0]    ones
);

    localparam int PW = $clog2(CHUNK + 1);

    // Sum the individual bits of the slice.
    always_comb begin
        ones = '0;
        for (int i = 0; i < CHUNK; i++) begin
            ones = ones + PW'(bits[i]);
        end
    end

endmodule

// File: rtl/logic_unit.sv
// Registered bitwise logic unit with valid/ready handshakes. Seven
// bitwise ops complete in one cycle; POPCOUNT walks the operand CHUNK
// bits per cycle. WIDTH must be >= 2 and a multiple of CHUNK.
module logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity
);

    localparam int CW     = count_width(WIDTH);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNTW   = $clog2(NCHUNK + 1);
    localparam int PW     = $clog2(CHUNK + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q;
    logic [CW-1:0]    acc_q;
    logic [CW-1:0]    acc_d;
    logic [CNTW-1:0]  cnt_q;
    logic [PW-1:0]    chunk_ones;
    logic [WIDTH-1:0] bitwise_res;
    logic [WIDTH-1:0] count_ext;
    logic [WIDTH-1:0] result_d;
    logic             accept;
    logic             last_chunk;
    logic             start_count;
    logic             load_result;
    logic             finish_count;

    // Ready depends only on state and the downstream ready, never on in_valid.
    assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    assign accept     = in_valid && in_ready;
    assign last_chunk = (cnt_q == CNTW'(1));

    popcount_chunk #(.CHUNK(CHUNK)) u_chunk (
        .bits (shift_q[CHUNK-1:0]),
        .ones (chunk_ones)
    );

    // Running popcount including the chunk currently at the bottom of the shifter.
    always_comb begin
        acc_d     = acc_q + CW'(chunk_ones);
        count_ext = '0;
        count_ext[CW-1:0] = acc_d;
    end

    // Single-cycle bitwise operation selected by op.
    always_comb begin
        bitwise_res = '0;
        case (op)
            OP_NOT:  bitwise_res = ~a;
            OP_AND:  bitwise_res = a & b;
            OP_OR:   bitwise_res = a | b;
            OP_XOR:  bitwise_res = a ^ b;
            OP_NAND: bitwise_res = ~(a & b);
            OP_NOR:  bitwise_res = ~(a | b);
            OP_XNOR: bitwise_res = ~(a ^ b);
            default: bitwise_res = '0;
        endcase
    end

    // Next-state logic; HOLD with out_ready behaves like IDLE for a new accept.
    always_comb begin
        state_d      = state_q;
        start_count  = 1'b0;
        load_result  = 1'b0;
        finish_count = 1'b0;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (accept) begin
                    if (op == OP_POPCOUNT) begin
                        state_d     = ST_COUNT;
                        start_count = 1'b1;
                    end else begin
                        state_d     = ST_HOLD;
                        load_result = 1'b1;
                    end
                end else if ((state_q == ST_HOLD) && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (last_chunk) begin
                    state_d      = ST_HOLD;
                    finish_count = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        result_d = finish_count ? count_ext : bitwise_res;
    end

    // State register; out_valid is kept as its own flop so it leaves the block registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_valid <= (state_d == ST_HOLD);
        end
    end

    // Result register and its flags, always updated together so they agree.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            zero   <= 1'b1;
            parity <= 1'b0;
        end else if (load_result || finish_count) begin
            result <= result_d;
            zero   <= (result_d == '0);
            parity <= ^result_d;
        end
    end

    // Popcount datapath: shifter, accumulator and remaining-chunk counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (start_count) begin
            shift_q <= a;
            acc_q   <= '0;
            cnt_q   <= CNTW'(NCHUNK);
        end else if (state_q == ST_COUNT) begin
            shift_q <= shift_q >> CHUNK;
            acc_q   <= acc_d;
            cnt_q   <= cnt_q - CNTW'(1);
        end
    end

endmodule

// File: tb/tb_logic_unit.sv
// Scoreboard bench for logic_unit (WIDTH=8, CHUNK=4): directed scenarios
// followed by randomized traffic with random backpressure.
module tb_logic_unit;

    localparam int WIDTH  = 8;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    typedef struct {
        logic [7:0] res;
        logic       z;
        logic       p;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] op = 3'd0;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] result;
    logic       zero;
    logic       parity;

    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    bit   rand_ready = 1'b0;
    bit   head_seen  = 1'b0;
    exp_t sb[$];

    logic_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .parity    (parity)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Random consumer backpressure during the randomized phase.
    always @(negedge clk) begin
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Reference behaviour straight from the operation table.
    function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        case (o)
            3'd0: e.res = ~x;
            3'd1: e.res = x & y;
            3'd2: e.res = x | y;
            3'd3: e.res = x ^ y;
            3'd4: e.res = ~(x & y);
            3'd5: e.res = ~(x | y);
            3'd6: e.res = ~(x ^ y);
            default: e.res = 8'($countones(x));
        endcase
        e.z   = (e.res == 8'd0);
        e.p   = ($countones(e.res) % 2) == 1;
        e.due = 0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Presents one operation at a negedge, waits for acceptance, records the expectation.
    task automatic applyStimulus(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        int   waited;
        in_valid = 1'b1;
        op = o;
        a  = x;
        b  = y;
        waited = 0;
        #1;
        while (!in_ready) begin
            if (waited >= 100) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
            waited++;
        end
        e = model(o, x, y);
        e.due = cycle + 1 + ((o == 3'd7) ? NCHUNK : 0);
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: checks first-appearance latency and compares data on each retirement.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            head_seen = 1'b0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL spurious_out_valid: got out_valid=1 expected 0 (empty scoreboard)");
            end else begin
                if (!head_seen) begin
                    checkOutput("latency_cycle", cycle, sb[0].due);
                    head_seen = 1'b1;
                end
                if (out_ready) begin
                    checkOutput("sb_result", result, sb[0].res);
                    checkOutput("sb_zero",   zero,   sb[0].z);
                    checkOutput("sb_parity", parity, sb[0].p);
                    void'(sb.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
    end

    initial begin
        int wait_cnt;
        logic [2:0] ro;

        // Reset values
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_result",    result,    0);
        checkOutput("reset_zero",      zero,      1);
        checkOutput("reset_parity",    parity,    0);
        checkOutput("reset_in_ready",  in_ready,  1);

        // Simple bitwise ops with the consumer always ready
        out_ready = 1'b1;
        applyStimulus(3'd0, 8'h5A, 8'h00);
        checkOutput("not_result", result, 8'hA5);
        checkOutput("not_zero",   zero,   0);
        checkOutput("not_parity", parity, 0);
        @(negedge clk);
        checkOutput("not_one_cycle_valid", out_valid, 0);

        applyStimulus(3'd1, 8'hF0, 8'h0F);
        checkOutput("and_zero", zero, 1);
        applyStimulus(3'd6, 8'hF0, 8'h0F);
        checkOutput("xnor_result", result, 8'h00);
        applyStimulus(3'd5, 8'h00, 8'h00);
        checkOutput("nor_result", result, 8'hFF);
        @(negedge clk);

        // POPCOUNT latency and in_ready during counting
        applyStimulus(3'd7, 8'hFF, 8'h00);
        for (int i = 0; i < NCHUNK; i++) begin
            checkOutput("count_in_ready_low", in_ready, 0);
            @(negedge clk);
        end
        checkOutput("pop_ff_result", result, 8'h08);
        checkOutput("pop_ff_parity", parity, 1);
        applyStimulus(3'd7, 8'h00, 8'h00);
        repeat (NCHUNK) @(negedge clk);
        checkOutput("pop_00_zero", zero, 1);
        @(negedge clk);

        // Backpressure holds the result, then retire and accept on one edge
        out_ready = 1'b0;
        applyStimulus(3'd2, 8'h81, 8'h18);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_out_valid", out_valid, 1);
            checkOutput("bp_result",    result,    8'h99);
            checkOutput("bp_in_ready",  in_ready,  0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        applyStimulus(3'd3, 8'h3C, 8'h0F);
        @(negedge clk);

        // Back-to-back XOR stream
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'd3, 8'($urandom), 8'($urandom));
        end
        @(negedge clk);

        // Reset in the middle of a popcount
        applyStimulus(3'd7, 8'hFF, 8'h00);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_result",    result,    0);
        checkOutput("midrst_zero",      zero,      1);
        checkOutput("midrst_in_ready",  in_ready,  1);
        applyStimulus(3'd0, 8'h00, 8'h00);
        checkOutput("post_rst_not", result, 8'hFF);
        @(negedge clk);

        // Randomized traffic with random gaps and random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ro = 3'($urandom_range(0, 7));
            applyStimulus(ro, 8'($urandom), 8'($urandom));
        end

        // Drain
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 200) begin
            @(negedge clk);
            wait_cnt++;
        end
        @(negedge clk);
        checkOutput("drain_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
